// File: rtl/times_table_axi_reader.sv
// rtl/times_table_axi_reader.sv - AXI4-Lite read master fetching a*b from the times-table slave
// Optional AXI_TIMEOUT_EN adds an AR/R handshake watchdog of TIMEOUT_CYCLES cycles.
module times_table_axi_reader #(
   parameter int                    ADDR_WIDTH     = 32,
   parameter int                    DATA_WIDTH     = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
   parameter int                    TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [2:0]            a,
   input  logic [2:0]            b,
   input  logic                  enable,
   output logic [5:0]            result,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [2:0]            m_axi_arprot,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t                state_q, state_d;
   logic [5:0]            result_q, result_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  arvalid_q, arvalid_d;
   logic                  rready_q, rready_d;
   logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;

`ifdef AXI_TIMEOUT_EN
   localparam int            CW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          timeout;
   logic          unused_bits;
   assign unused_bits = ^m_axi_rdata[DATA_WIDTH-1:6];
`else
   logic unused_bits;
   assign unused_bits = (^m_axi_rdata[DATA_WIDTH-1:6]) ^ (TIMEOUT_CYCLES > 0);
`endif

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = err_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      araddr_d  = araddr_q;
`ifdef AXI_TIMEOUT_EN
      // Counter restarts on every state entry; IDLE keeps it parked at zero.
      cnt_d   = (state_q == IDLE) ? '0 : cnt_q + 1'b1;
      timeout = (cnt_q == TO_LAST);
`endif
      case (state_q)
         IDLE: begin
            if (enable) begin
               araddr_d  = BASE_ADDR + ADDR_WIDTH'({a, b, 2'b00});
               arvalid_d = 1'b1;
               busy_d    = 1'b1;
               state_d   = ADDR;
            end
         end
         ADDR: begin
            if (m_axi_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = DATA;
`ifdef AXI_TIMEOUT_EN
               cnt_d     = '0;
`endif
            end
`ifdef AXI_TIMEOUT_EN
            else if (timeout) begin
               arvalid_d = 1'b0;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               err_d     = 1'b1;
               state_d   = IDLE;
            end
`endif
         end
         DATA: begin
            if (m_axi_rvalid) begin
               rready_d = 1'b0;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               state_d  = IDLE;
               // Error responses keep the last good product visible.
               if (m_axi_rresp == 2'b00) begin
                  result_d = m_axi_rdata[5:0];
                  err_d    = 1'b0;
               end else begin
                  err_d    = 1'b1;
               end
            end
`ifdef AXI_TIMEOUT_EN
            else if (timeout) begin
               rready_d = 1'b0;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               err_d    = 1'b1;
               state_d  = IDLE;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         result_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         araddr_q  <= '0;
`ifdef AXI_TIMEOUT_EN
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         araddr_q  <= araddr_d;
`ifdef AXI_TIMEOUT_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

   assign result        = result_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;
   assign m_axi_araddr  = araddr_q;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_times_table_axi_reader.sv
// tb/tb_times_table_axi_reader.sv - randomized bench for times_table_axi_reader against a product/address model
module tb_times_table_axi_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  a = '0;
   logic [2:0]  b = '0;
   logic        enable = 1'b0;
   logic [5:0]  result;
   logic        busy, done, err;
   logic [31:0] m_axi_araddr;
   logic [2:0]  m_axi_arprot;
   logic        m_axi_arvalid;
   logic        m_axi_arready = 1'b0;
   logic [31:0] m_axi_rdata = '0;
   logic [1:0]  m_axi_rresp = '0;
   logic        m_axi_rvalid = 1'b0;
   logic        m_axi_rready;

   int n_checks = 0;
   int n_err    = 0;
   int ar_hs    = 0;

   logic [5:0] exp_result = '0;
   logic       exp_err    = 1'b0;

   times_table_axi_reader #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'h0), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .enable(enable),
      .result(result), .busy(busy), .done(done), .err(err),
      .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (!rst && m_axi_arvalid && m_axi_arready) ar_hs++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full read; the slave side is driven here with the given delays and response.
   task automatic txn(input logic [2:0] ta, input logic [2:0] tb, input int ard, input int rd,
                      input logic [1:0] resp, input logic [31:0] data,
                      input bit poke, input bit keep, input bit started);
      logic [31:0] addr;
      int          hs0;
      addr = 32'(ta) * 32 + 32'(tb) * 4;
      hs0  = ar_hs;
      if (!started) begin
         a = ta; b = tb; enable = 1'b1;
         tick();
         enable = 1'b0;
      end
      check("arvalid_start", m_axi_arvalid, 1);
      check("busy_start", busy, 1);
      check("araddr", m_axi_araddr, addr);
      check("arprot", m_axi_arprot, 0);
      for (int i = 0; i < ard; i++) begin
         if (poke) begin a = 3'($urandom); b = 3'($urandom); enable = 1'b1; end
         tick();
         check("arvalid_hold", m_axi_arvalid, 1);
         check("araddr_hold", m_axi_araddr, addr);
      end
      m_axi_arready = 1'b1;
      tick();
      m_axi_arready = 1'b0;
      check("arvalid_drop", m_axi_arvalid, 0);
      check("rready_up", m_axi_rready, 1);
      for (int i = 0; i < rd; i++) begin
         if (poke) begin a = 3'($urandom); b = 3'($urandom); enable = 1'b1; end
         tick();
         check("rready_hold", m_axi_rready, 1);
         check("done_early", done, 0);
      end
      a = ta; b = tb; enable = keep;
      m_axi_rvalid = 1'b1; m_axi_rdata = data; m_axi_rresp = resp;
      tick();
      m_axi_rvalid = 1'b0;
      if (resp == 2'b00) begin exp_result = data[5:0]; exp_err = 1'b0; end
      else exp_err = 1'b1;
      check("done_pulse", done, 1);
      check("busy_end", busy, 0);
      check("rready_end", m_axi_rready, 0);
      check("result", result, exp_result);
      check("err", err, exp_err);
      check("ar_handshakes", ar_hs - hs0, 1);
      tick();
      enable = 1'b0;
      check("done_one_cycle", done, 0);
      check("restart_arvalid", m_axi_arvalid, keep);
      check("restart_busy", busy, keep);
   endtask

   initial begin
      logic [2:0]  ra, rb;
      logic [1:0]  rr;
      logic [31:0] rdat;
      repeat (2) tick();
      rst = 1'b0;
      check("rst_result", result, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_arvalid", m_axi_arvalid, 0);
      check("rst_rready", m_axi_rready, 0);
      check("rst_araddr", m_axi_araddr, 0);

      txn(3'd3, 3'd3, 0, 0, 2'b00, 32'd9, 0, 0, 0);
      txn(3'd5, 3'd6, 3, 1, 2'b00, 32'd30, 1, 0, 0);
      txn(3'd4, 3'd2, 1, 2, 2'b10, 32'd63, 0, 0, 0);
      check("slverr_keeps_result", result, 30);

      // Reset while waiting for R.
      a = 3'd2; b = 3'd4; enable = 1'b1;
      tick();
      enable = 1'b0; m_axi_arready = 1'b1;
      tick();
      m_axi_arready = 1'b0;
      check("in_data_rready", m_axi_rready, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_result = '0; exp_err = 1'b0;
      check("rstdata_arvalid", m_axi_arvalid, 0);
      check("rstdata_rready", m_axi_rready, 0);
      check("rstdata_busy", busy, 0);
      check("rstdata_result", result, exp_result);
      check("rstdata_err", err, exp_err);
      tick();

      txn(3'd7, 3'd7, 0, 0, 2'b00, 32'hFFFF_FF31, 0, 0, 0);
      txn(3'd2, 3'd3, 0, 0, 2'b00, 32'd6, 0, 1, 0);
      txn(3'd2, 3'd3, 1, 0, 2'b11, 32'd0, 0, 0, 1);

      for (int n = 0; n < 40; n++) begin
         ra   = 3'($urandom);
         rb   = 3'($urandom);
         rr   = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         rdat = ($urandom << 6) | (32'(ra) * 32'(rb));
         txn(ra, rb, $urandom_range(0, 4), $urandom_range(0, 4), rr, rdat,
             bit'($urandom_range(0, 1)), 0, 0);
         if ($urandom_range(0, 1) == 1) tick();
      end

`ifdef AXI_TIMEOUT_EN
      a = 3'd1; b = 3'd2; enable = 1'b1;
      tick();
      enable = 1'b0; m_axi_arready = 1'b1;
      tick();
      m_axi_arready = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         check("to_wait_done", done, 0);
      end
      tick();
      check("to_done", done, 1);
      check("to_err", err, 1);
      check("to_busy", busy, 0);
      check("to_rready", m_axi_rready, 0);
      check("to_result", result, exp_result);
      tick();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
